relu_requant_vecbuf: RTL and testbench

- Downstream stage of the bit-serial MAC engine. Consumes its per-neuron accumulator stream using a valid/ready handshake.
- Each accumulator passes through optional ReLU, then an arithmetic right-shift requantize with rounding, then saturation to DATA_W.
- Results are assembled into a full N_HIDDEN-element vector buffer. The buffer is presented as a flat bus that feeds the next layer's input vector.

---
 rtl/relu_requant_vecbuf.sv | 135 +++++++++++++
 tb/tb_relu_requant_vecbuf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_requant_vecbuf.sv
`default_nettype none
// ============================================================================
// Module   : relu_requant_vecbuf
// Purpose  : ReLU + shift requantize + saturate of MAC accumulators, packed
//            into an N_HIDDEN-element vector buffer for the next layer.
//            Build option RQ_ROUND_EN: round half up (default: truncate).
// Revision : 1.0 - initial release
// ============================================================================
module relu_requant_vecbuf #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 128,
    parameter int N_HIDDEN = 64,
    parameter int SHIFT_W  = 6,
    localparam int ACC_W   = 2*DATA_W + $clog2((N_IN > 2) ? N_IN : 2),
    localparam int SC_W    = $clog2(N_HIDDEN) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [ACC_W-1:0]    in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       relu_en,
    output logic [N_HIDDEN*DATA_W-1:0] vec_bus,
    output logic                       vec_valid,
    input  logic                       vec_ready,
    output logic [SC_W-1:0]            sat_count,
    output logic                       busy
);

    localparam int                  c_IDX_W    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(N_HIDDEN - 1);
    localparam logic [SC_W-1:0]     c_SAT_MAX  = '1;
    localparam logic signed [ACC_W:0] c_SAT_HI =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_SAT_LO =
        {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic [0:0] c_FILL = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_next;
    logic [c_IDX_W-1:0]         r_wr_idx;
    logic [SHIFT_W-1:0]         r_shift;
    logic                       r_relu;
    logic [SC_W-1:0]            r_sat_count;
    logic [N_HIDDEN*DATA_W-1:0] r_vec;

    logic                       w_accept;
    logic                       w_first;
    logic [SHIFT_W-1:0]         w_shift;
    logic                       w_relu;
    logic signed [ACC_W:0]      w_x;
    logic signed [ACC_W:0]      w_r;
    logic signed [ACC_W:0]      w_q;
    logic                       w_sat;
    logic [DATA_W-1:0]          w_elem;

    assign w_accept = in_valid && (r_state == c_FILL);
    assign w_first  = (r_wr_idx == '0);
    // The first beat of a vector uses the live controls; later beats use the latched copy.
    assign w_shift  = w_first ? shift   : r_shift;
    assign w_relu   = w_first ? relu_en : r_relu;

    assign w_x = {in_data[ACC_W-1], in_data};
    assign w_r = (w_relu && w_x[ACC_W]) ? '0 : w_x;

`ifdef RQ_ROUND_EN
    logic signed [ACC_W:0] w_bias;
    logic signed [ACC_W:0] w_sum;
    assign w_bias = (w_shift == '0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (w_shift - 1'b1));
    assign w_sum  = w_r + w_bias;
    assign w_q    = w_sum >>> w_shift;
`else
    assign w_q    = w_r >>> w_shift;
`endif

    always_comb begin
        w_sat  = 1'b0;
        w_elem = w_q[DATA_W-1:0];
        if (w_q > c_SAT_HI) begin
            w_sat  = 1'b1;
            w_elem = c_SAT_HI[DATA_W-1:0];
        end else if (w_q < c_SAT_LO) begin
            w_sat  = 1'b1;
            w_elem = c_SAT_LO[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_FILL;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_FILL:  if (w_accept && (r_wr_idx == c_LAST_IDX)) w_state_next = c_HOLD;
            c_HOLD:  if (vec_ready) w_state_next = c_FILL;
            default: w_state_next = c_FILL;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_FILL);
        vec_valid = (r_state == c_HOLD);
        busy      = (r_state == c_HOLD) || (r_wr_idx != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx    <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_sat_count <= '0;
            r_vec       <= '0;
        end else if (w_accept) begin
            r_vec[r_wr_idx*DATA_W +: DATA_W] <= w_elem;
            if (w_first) begin
                r_shift     <= shift;
                r_relu      <= relu_en;
                r_sat_count <= SC_W'(w_sat);
            end else if (w_sat && (r_sat_count != c_SAT_MAX)) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
            r_wr_idx <= (r_wr_idx == c_LAST_IDX) ? '0 : r_wr_idx + 1'b1;
        end
    end

    assign vec_bus   = r_vec;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_relu_requant_vecbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_requant_vecbuf
// Purpose  : Randomized + directed bench for relu_requant_vecbuf against a
//            behavioural vector model. Honours RQ_ROUND_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_requant_vecbuf;

    localparam int DATA_W   = 16;
    localparam int N_IN     = 128;
    localparam int N_HIDDEN = 64;
    localparam int SHIFT_W  = 6;
    localparam int ACC_W    = 2*DATA_W + $clog2((N_IN > 2) ? N_IN : 2);
    localparam int SC_W     = $clog2(N_HIDDEN) + 1;

`ifdef RQ_ROUND_EN
    localparam longint c_RND_POS = 2;
    localparam longint c_RND_NEG = -1;
`else
    localparam longint c_RND_POS = 1;
    localparam longint c_RND_NEG = -2;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic signed [ACC_W-1:0]    in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [SHIFT_W-1:0]         shift;
    logic                       relu_en;
    logic [N_HIDDEN*DATA_W-1:0] vec_bus;
    logic                       vec_valid;
    logic                       vec_ready;
    logic [SC_W-1:0]            sat_count;
    logic                       busy;

    relu_requant_vecbuf #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .shift(shift), .relu_en(relu_en),
        .vec_bus(vec_bus), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .sat_count(sat_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint elem(input int k);
        logic signed [DATA_W-1:0] v;
        v = vec_bus[k*DATA_W +: DATA_W];
        return longint'(v);
    endfunction

    // Specification-level arithmetic: floor division by 2^s, optional half-up bias, clamp.
    function automatic longint spec_elem(input longint x, input int s, input bit relu,
                                         output bit sat);
        longint r, d, q, hi, lo;
        r = (relu && x < 0) ? 0 : x;
        d = longint'(1) << s;
`ifdef RQ_ROUND_EN
        if (s > 0) r = r + d / 2;
`endif
        q = r / d;
        if (r < 0 && (r % d) != 0) q = q - 1;
        hi  = (longint'(1) << (DATA_W-1)) - 1;
        lo  = -hi - 1;
        sat = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    // Behavioural model of the vector buffer
    longint m_vec [N_HIDDEN];
    int     m_idx, m_sat, m_shift;
    bit     m_relu, m_hold, m_busy;
    bit     started = 1'b0;

    always @(posedge clk) begin
        bit     s;
        longint v;
        started = 1'b1;
        if (rst) begin
            foreach (m_vec[k]) m_vec[k] = 0;
            m_idx = 0; m_sat = 0; m_shift = 0; m_relu = 0; m_hold = 0; m_busy = 0;
        end else if (m_hold) begin
            if (vec_ready) begin m_hold = 0; m_busy = 0; end
        end else if (in_valid) begin
            if (m_idx == 0) begin m_shift = int'(shift); m_relu = relu_en; m_sat = 0; end
            v = spec_elem(longint'(in_data), m_shift, m_relu, s);
            m_vec[m_idx] = v;
            if (s && m_sat < (1 << SC_W) - 1) m_sat++;
            m_busy = 1;
            if (m_idx == N_HIDDEN-1) begin m_idx = 0; m_hold = 1; end
            else m_idx++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",  in_ready,  !m_hold);
            chk("vec_valid", vec_valid, m_hold);
            chk("busy",      busy,      m_busy);
            chk("sat_count", sat_count, m_sat);
            for (int k = 0; k < N_HIDDEN; k++) chk($sformatf("elem%0d", k), elem(k), m_vec[k]);
        end
    end

    longint beat_data  [N_HIDDEN];
    int     beat_shift [N_HIDDEN];
    bit     beat_relu  [N_HIDDEN];

    function automatic longint rand_acc();
        longint v;
        int     b;
        b = $urandom_range(ACC_W, 1);
        v = longint'({$urandom, $urandom});
        v = v <<< (64 - b);
        return v >>> (64 - b);
    endfunction

    task automatic fill_rand(input int s, input bit r);
        for (int i = 0; i < N_HIDDEN; i++) begin
            beat_data[i] = rand_acc(); beat_shift[i] = s; beat_relu[i] = r;
        end
    endtask

    task automatic send(input int start, input int n, input int gap_pct);
        bit acc;
        int budget;
        for (int i = start; i < start + n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0; @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = beat_data[i][ACC_W-1:0];
            shift    = SHIFT_W'(beat_shift[i]);
            relu_en  = beat_relu[i];
            budget   = 0;
            do begin
                acc = in_ready; @(posedge clk); #1; budget++;
            end while (!acc && budget < 200);
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: beat %0d not accepted, got in_ready=0, expected 1", i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic consume(input int dly);
        int t = 0;
        while (!vec_valid && t < 200) begin @(posedge clk); #1; t++; end
        if (!vec_valid) begin
            n_checks++; n_fail++;
            $display("FAIL consume_timeout: got vec_valid=0, expected 1");
        end
        repeat (dly) begin @(posedge clk); #1; end
        vec_ready = 1'b1; @(posedge clk); #1; vec_ready = 1'b0;
    endtask

    initial begin
        logic [N_HIDDEN*DATA_W-1:0] snap;
        int t0, nz;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; shift = '0; relu_en = 1'b0; vec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat", sat_count, 0);
        chk("rst_bus_zero", vec_bus == '0, 1);

        // Rounding
        fill_rand(4, 0); beat_data[0] = 24; beat_data[1] = -24;
        send(0, N_HIDDEN, 0);
        chk("round_pos", elem(0), c_RND_POS);
        chk("round_neg", elem(1), c_RND_NEG);
        chk("model_round_pos", m_vec[0], c_RND_POS);
        consume(2);

        // ReLU with mid-vector control flip ignored
        for (int i = 0; i < N_HIDDEN; i++) begin
            beat_data[i]  = -longint'($urandom_range(100000, 1));
            beat_shift[i] = (i < 5) ? 0 : 3;
            beat_relu[i]  = (i < 5);
        end
        beat_data[0] = -500;
        send(0, N_HIDDEN, 10);
        chk("relu_on", elem(0), 0);
        nz = 0;
        for (int k = 5; k < N_HIDDEN; k++) if (elem(k) != 0) nz++;
        chk("relu_flip_ignored", nz, 0);
        consume(1);
        fill_rand(0, 0); beat_data[0] = -500;
        send(0, N_HIDDEN, 0);
        chk("relu_off_hex", longint'(vec_bus[DATA_W-1:0]), 'hFE0C);
        consume(0);

        // Saturation
        fill_rand(0, 0);
        for (int i = 0; i < N_HIDDEN; i++) beat_data[i] = 7;
        beat_data[0] = 40000; beat_data[1] = -40000;
        send(0, N_HIDDEN, 0);
        chk("sat_hi", elem(0), 32767);
        chk("sat_lo", elem(1), -32768);
        chk("sat_mid", elem(2), 7);
        chk("sat_count2", sat_count, 2);
        chk("model_sat_count", m_sat, 2);
        consume(3);
        for (int i = 0; i < N_HIDDEN; i++) beat_data[i] = 5;
        send(0, 1, 0);
        chk("sat_cleared", sat_count, 0);
        send(1, N_HIDDEN-1, 20);
        consume(0);

        // Backpressure
        fill_rand(2, 0);
        send(0, N_HIDDEN, 0);
        snap = vec_bus;
        in_valid = 1'b1; in_data = '1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("bp_bus_stable", vec_bus == snap, 1);
        chk("bp_valid_held", vec_valid, 1);
        vec_ready = 1'b1; @(posedge clk); #1; vec_ready = 1'b0; in_valid = 1'b0;
        chk("bp_valid_fall", vec_valid, 0);
        chk("bp_ready_rise", in_ready, 1);

        // Back-to-back handshake timing
        fill_rand(1, 1);
        t0 = cyc;
        send(0, N_HIDDEN, 0);
        chk("hs_cycles", cyc - t0, N_HIDDEN);
        chk("hs_vec_valid", vec_valid, 1);
        chk("hs_busy", busy, 1);
        consume(0);

        // Reset mid-fill
        fill_rand(0, 0);
        send(0, 10, 0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        chk("mr_bus_zero", vec_bus == '0, 1);
        chk("mr_sat", sat_count, 0);
        chk("mr_valid", vec_valid, 0);
        chk("mr_busy", busy, 0);
        fill_rand(0, 0); beat_data[0] = 123;
        send(0, N_HIDDEN, 0);
        chk("mr_elem0", elem(0), 123);
        consume(1);

        // Randomized vectors with per-beat control churn
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N_HIDDEN; i++) begin
                beat_data[i]  = rand_acc();
                beat_shift[i] = $urandom_range(ACC_W-1, 0);
                beat_relu[i]  = 1'($urandom_range(1, 0));
            end
            send(0, N_HIDDEN, 30);
            consume($urandom_range(4, 0));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
